stream_frame_ctrl: RTL and testbench
====================================

Name: stream_frame_ctrl

Overview:
- Frame sequencer between the host 64-bit stream ports and the app wrapper (serializer, pixel circuit, deserializer).
- Admits exactly cfg_in_words input words per frame and releases exactly cfg_out_words output words per frame, then signals done.
- Lets the host run fixed-ratio kernels such as 1-per-32 downsampling frame by frame, with no stray words crossing frame boundaries.
- Data paths are combinational pass-through; the block only gates the valid/ready handshakes.

Parameters:
- CNT_W, 32, width of the word counters and cfg inputs.
- TIMEOUT_CYCLES, 65536, idle-cycle limit in RUN; used only when STREAM_FRAME_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin frame; sampled only in IDLE.
- cfg_in_words  in  CNT_W  input words in the frame; latched on accepted start.
- cfg_out_words  in  CNT_W  output words in the frame; latched on accepted start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at frame end.
- timeout  out  1  frame ended by watchdog; valid with done.
- h_din  in  64  host input data.
- h_din_valid  in  1  host input valid.
- h_din_ready  out  1  host input ready.
- a_din  out  64  to app din; always equals h_din.
- a_din_valid  out  1  to app din_valid.
- a_din_ready  in  1  from app din_ready.
- a_dout  in  64  from app dout.
- a_dout_valid  in  1  from app dout_valid.
- a_dout_ready  out  1  to app dout_ready.
- h_dout  out  64  host output data; always equals a_dout.
- h_dout_valid  out  1  host output valid.
- h_dout_ready  in  1  host output ready.

Behaviour:
- States: IDLE, RUN, DONE. On reset: state=IDLE, counters=0, latched cfg=0, busy=0, done=0, timeout=0.
- Input and output gating:
  - in_open = (state==RUN) && (in_cnt < in_lim).
  - a_din_valid = h_din_valid & in_open; h_din_ready = a_din_ready & in_open.
  - out_open = (state==RUN) && (out_cnt < out_lim).
  - h_dout_valid = a_dout_valid & out_open; a_dout_ready = h_dout_ready & out_open.
- Gating adds zero latency: handshake outputs are combinational from the inputs plus registered state.
- Counting:
  - in_cnt increments on a_din_valid & a_din_ready; out_cnt increments on h_dout_valid & h_dout_ready.
  - Both counters are cleared on an accepted start and never exceed their latched limit.
- IDLE: start=1 latches in_lim and out_lim, clears the counters and goes to RUN. If both cfg values are 0, it goes straight to DONE.
- RUN: go to DONE on the cycle after both in_cnt==in_lim and out_cnt==out_lim hold. A final-word transfer in cycle N means done is asserted in cycle N+1.
- DONE: done=1 for exactly one cycle, then IDLE.
- Boundary conditions:
  - Input completing before output is normal; input stays gated while output drains.
  - Output limit reached before input limit: output stays gated and extra app words are held in the app for the next frame. Input continues until its limit.
  - start outside IDLE is ignored; cfg changes outside IDLE are ignored.
  - Input and output transfers in the same cycle are both counted.
  - rst_n asserted mid-frame returns to IDLE immediately, with all handshake outputs low and counters cleared.

Optional Feature:
- STREAM_FRAME_CTRL_TIMEOUT_EN defined:
  - A CNT_W idle counter runs in RUN, cleared on any counted transfer and on entry to RUN.
  - When it reaches TIMEOUT_CYCLES-1 with no transfer that cycle, the next state is DONE.
  - timeout=1 together with the done pulse; timeout returns to 0 in IDLE.
- Not defined: no idle counter; timeout is tied to 0; RUN waits indefinitely.

Test Plan:
- cfg_in=64, cfg_out=2, start, host streams 64 words with valid held high and app ready high, 2 outputs returned -> exactly 64 input and 2 output transfers; done pulses once on the cycle after the 2nd output; busy low afterwards.
- Same frame with the host offering a 65th word -> h_din_ready=0 after 64 transfers; the 65th word is not consumed.
- cfg_in=4, cfg_out=1, app presents 2 output words -> 1 transferred; a_dout_ready=0 with the 2nd pending; the 2nd transfers only after the next start.
- cfg_in=0, cfg_out=0, start -> done in the cycle after start with no transfers; start during RUN has no effect on counters or limits.
- rst_n pulsed low mid-frame after 10 inputs -> all outputs 0 immediately; a following start with new cfg runs a clean frame.
- With STREAM_FRAME_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, app stalls after 3 inputs -> done and timeout high together after 16 idle cycles; without the macro, busy stays high.

Source files
------------

// File: rtl/stream_frame_ctrl_if.sv
//------------------------------------------------------------------------------
// stream_frame_ctrl_if
//
// Purpose : Bundles the host-side and app-side 64-bit stream handshakes that
//           the frame controller sits between.
//
// Signals :
//   h_din / h_din_valid / h_din_ready     host -> controller input stream
//   a_din / a_din_valid / a_din_ready     controller -> app input stream
//   a_dout / a_dout_valid / a_dout_ready  app -> controller output stream
//   h_dout / h_dout_valid / h_dout_ready  controller -> host output stream
//
// Modports:
//   slave  : the frame controller itself
//   master : the surrounding environment (host plus app wrapper)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface stream_frame_ctrl_if;
    logic [63:0] h_din;
    logic        h_din_valid;
    logic        h_din_ready;

    logic [63:0] a_din;
    logic        a_din_valid;
    logic        a_din_ready;

    logic [63:0] a_dout;
    logic        a_dout_valid;
    logic        a_dout_ready;

    logic [63:0] h_dout;
    logic        h_dout_valid;
    logic        h_dout_ready;

    modport slave (
        input  h_din, h_din_valid, a_din_ready, a_dout, a_dout_valid, h_dout_ready,
        output h_din_ready, a_din, a_din_valid, a_dout_ready, h_dout, h_dout_valid
    );

    modport master (
        output h_din, h_din_valid, a_din_ready, a_dout, a_dout_valid, h_dout_ready,
        input  h_din_ready, a_din, a_din_valid, a_dout_ready, h_dout, h_dout_valid
    );
endinterface

// File: rtl/stream_frame_ctrl.sv
//------------------------------------------------------------------------------
// stream_frame_ctrl
//
// Purpose : Frame sequencer between the host stream ports and the app wrapper.
//           Admits exactly cfg_in_words input words and releases exactly
//           cfg_out_words output words per frame, then pulses done. Data is a
//           combinational pass-through; only the valid/ready pairs are gated.
//
// Ports   :
//   clk            single clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a frame (sampled only in IDLE)
//   cfg_in_words   input words per frame, latched on accepted start
//   cfg_out_words  output words per frame, latched on accepted start
//   busy           high while the frame is running
//   done           one-cycle pulse at frame end
//   timeout        frame was ended by the watchdog, valid together with done
//   bus            stream_frame_ctrl_if.slave, host/app handshakes
//
// Options :
//   STREAM_FRAME_CTRL_TIMEOUT_EN  when defined, an idle watchdog ends a frame
//                                 after TIMEOUT_CYCLES cycles without a
//                                 transfer; otherwise RUN waits indefinitely.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module stream_frame_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_in_words,
    input  logic [CNT_W-1:0] cfg_out_words,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    stream_frame_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] in_lim_q, in_lim_d;
    logic [CNT_W-1:0] out_lim_q, out_lim_d;
    logic [CNT_W-1:0] in_next, out_next;
    logic             in_open, out_open;
    logic             in_fire, out_fire;
    logic             frame_done;
    logic             wd_expire;

    // A side of the frame is open only while running and below its limit,
    // which is what keeps the counters from ever passing the latched limit.
    assign in_open  = (state_q == RUN) && (in_cnt_q < in_lim_q);
    assign out_open = (state_q == RUN) && (out_cnt_q < out_lim_q);

    assign bus.a_din        = bus.h_din;
    assign bus.a_din_valid  = bus.h_din_valid & in_open;
    assign bus.h_din_ready  = bus.a_din_ready & in_open;

    assign bus.h_dout       = bus.a_dout;
    assign bus.h_dout_valid = bus.a_dout_valid & out_open;
    assign bus.a_dout_ready = bus.h_dout_ready & out_open;

    assign in_fire  = bus.h_din_valid & bus.a_din_ready & in_open;
    assign out_fire = bus.a_dout_valid & bus.h_dout_ready & out_open;

    assign in_next  = in_fire  ? in_cnt_q  + CNT_W'(1) : in_cnt_q;
    assign out_next = out_fire ? out_cnt_q + CNT_W'(1) : out_cnt_q;

    // Looking at the post-transfer counts lets done follow the final word
    // by exactly one cycle.
    assign frame_done = (state_q == RUN) && (in_next == in_lim_q) && (out_next == out_lim_q);

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

`ifdef STREAM_FRAME_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             timeout_q, timeout_d;

    // Idle counter: held at zero outside RUN (so it starts clean on entry)
    // and on any counted transfer; otherwise it climbs to its last value.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if ((state_q != RUN) || in_fire || out_fire) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_LAST) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
    end

    assign wd_expire = (state_q == RUN) && !in_fire && !out_fire && (idle_cnt_q == IDLE_LAST);

    // The flag is only raised on the RUN->DONE step caused by the watchdog,
    // so it is high exactly during the done cycle.
    assign timeout_d = wd_expire && !frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;

    // No watchdog in this build: the flag is constant low.
    assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    // Next-state and counter logic. Limits only change on an accepted start,
    // so start or cfg activity outside IDLE has no effect.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        in_lim_d  = in_lim_q;
        out_lim_d = out_lim_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    in_lim_d  = cfg_in_words;
                    out_lim_d = cfg_out_words;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    if ((cfg_in_words == '0) && (cfg_out_words == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                in_cnt_d  = in_next;
                out_cnt_d = out_next;
                if (frame_done || wd_expire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and limit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            in_lim_q  <= '0;
            out_lim_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            in_lim_q  <= in_lim_d;
            out_lim_q <= out_lim_d;
        end
    end

endmodule

// File: tb/tb_stream_frame_ctrl.sv
//------------------------------------------------------------------------------
// tb_stream_frame_ctrl
//
// Purpose : Self-checking bench for stream_frame_ctrl. The bench plays host
//           and app; every word offered is queued as the expected stream, and
//           a negedge monitor compares transferred data and the handshake /
//           status outputs against a frame-level model built from word
//           budgets (remaining words, idle run length).
//
// Options : STREAM_FRAME_CTRL_TIMEOUT_EN selects the watchdog expectations.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stream_frame_ctrl;

    localparam int CNT_W = 32;
    localparam int TMO   = 16;
`ifdef STREAM_FRAME_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfgIn  = '0;
    logic [CNT_W-1:0] cfgOut = '0;
    logic             busy, done, timeout;

    stream_frame_ctrl_if bus ();

    stream_frame_ctrl #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_in_words  (cfgIn),
        .cfg_out_words (cfgOut),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Words the bench host/app still has to hand over, and the streams the
    // DUT must reproduce in order on the far side.
    logic [63:0] hostQ[$];
    logic [63:0] appQ[$];
    logic [63:0] expIn[$];
    logic [63:0] expOut[$];

    int hostBudget = 1 << 30;
    int appBudget  = 1 << 30;
    bit hostSteady = 1'b0;
    bit appSteady  = 1'b0;

    // Transfers seen by the monitor, consumed by the driver after the edge.
    bit hostX = 1'b0;
    bit appX  = 1'b0;

    // Frame-level reference state.
    bit mActive = 1'b0;
    bit mPulse  = 1'b0;
    bit mTmo    = 1'b0;
    int mRemIn  = 0;
    int mRemOut = 0;
    int mIdle   = 0;
    int mLimIn  = 0;
    int mLimOut = 0;

    int dutFrameIn  = 0;
    int dutFrameOut = 0;
    bit sawTimeoutDone = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host and app driver: retire words that moved on the last edge, then
    // present the next ones with randomized or steady valid/ready.
    initial begin
        logic [63:0] dummy;
        bus.h_din        = '0;
        bus.h_din_valid  = 1'b0;
        bus.a_din_ready  = 1'b0;
        bus.a_dout       = '0;
        bus.a_dout_valid = 1'b0;
        bus.h_dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hostX && hostQ.size() > 0) begin
                dummy = hostQ.pop_front();
                hostBudget--;
            end
            if (appX && appQ.size() > 0) begin
                dummy = appQ.pop_front();
                appBudget--;
            end
            bus.h_din_valid  = (hostQ.size() > 0) && (hostBudget > 0) &&
                               (hostSteady || ($urandom_range(0, 3) != 0));
            bus.h_din        = (hostQ.size() > 0) ? hostQ[0] : 64'h0;
            bus.a_din_ready  = appSteady || ($urandom_range(0, 3) != 0);
            bus.a_dout_valid = (appQ.size() > 0) && (appBudget > 0) &&
                               (appSteady || ($urandom_range(0, 3) != 0));
            bus.a_dout       = (appQ.size() > 0) ? appQ[0] : 64'h0;
            bus.h_dout_ready = hostSteady || ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        bit          expInOpen, expOutOpen, mInX, mOutX;
        logic [63:0] w;
        if (!rst_n) begin
            mActive = 1'b0;
            mPulse  = 1'b0;
            mTmo    = 1'b0;
            mRemIn  = 0;
            mRemOut = 0;
            mIdle   = 0;
            hostX   = 1'b0;
            appX    = 1'b0;
        end else begin
            expInOpen  = mActive && (mRemIn > 0);
            expOutOpen = mActive && (mRemOut > 0);

            checkOutput("busy", busy, mActive);
            checkOutput("done", done, mPulse);
            checkOutput("timeout", timeout, mPulse && mTmo);
            checkOutput("h_din_ready", bus.h_din_ready, bus.a_din_ready && expInOpen);
            checkOutput("a_din_valid", bus.a_din_valid, bus.h_din_valid && expInOpen);
            checkOutput("h_dout_valid", bus.h_dout_valid, bus.a_dout_valid && expOutOpen);
            checkOutput("a_dout_ready", bus.a_dout_ready, bus.h_dout_ready && expOutOpen);

            if (mPulse && !mTmo) begin
                checkOutput("frame_in_count", dutFrameIn, mLimIn);
                checkOutput("frame_out_count", dutFrameOut, mLimOut);
            end
            if (done && timeout) sawTimeoutDone = 1'b1;

            hostX = bus.h_din_valid && bus.h_din_ready;
            appX  = bus.a_dout_valid && bus.a_dout_ready;

            if (bus.a_din_valid && bus.a_din_ready) begin
                dutFrameIn++;
                if (expIn.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL a_din_extra: got %0h, required no transfer", bus.a_din);
                end else begin
                    w = expIn.pop_front();
                    checkOutput("a_din_data", bus.a_din, w);
                end
            end
            if (bus.h_dout_valid && bus.h_dout_ready) begin
                dutFrameOut++;
                if (expOut.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL h_dout_extra: got %0h, required no transfer", bus.h_dout);
                end else begin
                    w = expOut.pop_front();
                    checkOutput("h_dout_data", bus.h_dout, w);
                end
            end

            mInX  = bus.h_din_valid && bus.a_din_ready && expInOpen;
            mOutX = bus.a_dout_valid && bus.h_dout_ready && expOutOpen;
            if (mPulse) begin
                mPulse = 1'b0;
                mTmo   = 1'b0;
            end else if (mActive) begin
                mRemIn  = mRemIn - int'(mInX);
                mRemOut = mRemOut - int'(mOutX);
                if (mRemIn == 0 && mRemOut == 0) begin
                    mActive = 1'b0;
                    mPulse  = 1'b1;
                end else if (TMO_EN && !mInX && !mOutX && mIdle == TMO - 1) begin
                    mActive = 1'b0;
                    mPulse  = 1'b1;
                    mTmo    = 1'b1;
                end else if (mInX || mOutX) begin
                    mIdle = 0;
                end else begin
                    mIdle++;
                end
            end else if (start) begin
                mLimIn      = int'(cfgIn);
                mLimOut     = int'(cfgOut);
                mRemIn      = mLimIn;
                mRemOut     = mLimOut;
                mIdle       = 0;
                dutFrameIn  = 0;
                dutFrameOut = 0;
                if (mLimIn == 0 && mLimOut == 0) mPulse = 1'b1;
                else mActive = 1'b1;
            end
        end
    end

    // Queue fresh host/app words (also as the expected streams) and issue a
    // one-cycle start with the given frame sizes.
    task automatic applyStimulus(input int nIn, input int nOut, input int nHost, input int nApp);
        logic [63:0] w;
        for (int i = 0; i < nHost; i++) begin
            w = {$urandom, $urandom};
            hostQ.push_back(w);
            expIn.push_back(w);
        end
        for (int i = 0; i < nApp; i++) begin
            w = {$urandom, $urandom};
            appQ.push_back(w);
            expOut.push_back(w);
        end
        @(posedge clk);
        #2;
        start  = 1'b1;
        cfgIn  = CNT_W'(nIn);
        cfgOut = CNT_W'(nOut);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while ((mActive || mPulse) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (mActive || mPulse) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: got no frame end, required end within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int n;

        // Reset state
        #12;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_timeout", timeout, 1'b0);
        checkOutput("rst_h_din_ready", bus.h_din_ready, 1'b0);
        checkOutput("rst_a_dout_ready", bus.a_dout_ready, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // 64-in / 2-out frame with a 65th host word waiting; start mid-run ignored
        hostSteady = 1'b1;
        appSteady  = 1'b1;
        applyStimulus(64, 2, 65, 2);
        repeat (5) @(posedge clk);
        #2;
        start  = 1'b1;
        cfgIn  = CNT_W'(3);
        cfgOut = CNT_W'(3);
        @(posedge clk);
        #2;
        start = 1'b0;
        waitIdle(200, "frame64_end");
        checkOutput("frame64_word65_kept", hostQ.size(), 1);

        // Output limit hit first: second app word is held for the next frame
        applyStimulus(4, 1, 3, 2);
        waitIdle(200, "frame4_end");
        repeat (3) @(posedge clk);
        #2;
        checkOutput("held_app_word", appQ.size(), 1);
        applyStimulus(2, 1, 2, 0);
        waitIdle(200, "frame2_end");
        checkOutput("held_word_drained", appQ.size(), 0);

        // Empty frame
        applyStimulus(0, 0, 0, 0);
        waitIdle(20, "frame0_end");

        // Reset mid-frame after about 10 inputs
        applyStimulus(20, 3, 20, 3);
        n = 0;
        while (dutFrameIn < 10 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_h_din_ready", bus.h_din_ready, 1'b0);
        checkOutput("midrst_a_din_valid", bus.a_din_valid, 1'b0);
        checkOutput("midrst_h_dout_valid", bus.h_dout_valid, 1'b0);
        checkOutput("midrst_a_dout_ready", bus.a_dout_ready, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(6, 2, 0, 2);
        waitIdle(200, "post_reset_end");

        // Stall after 3 inputs with no app output
        sawTimeoutDone = 1'b0;
        hostBudget = 3;
        appBudget  = 0;
        applyStimulus(8, 8, 8, 8);
        repeat (40) @(posedge clk);
        #2;
        checkOutput("stall_busy", busy, !TMO_EN);
        checkOutput("stall_timeout_done", sawTimeoutDone, TMO_EN);
        hostBudget = 1 << 30;
        appBudget  = 1 << 30;
        waitIdle(300, "stall_end");

        // Randomized frames
        hostSteady = 1'b0;
        appSteady  = 1'b0;
        for (int f = 0; f < 25; f++) begin
            int nIn, nOut;
            nIn  = $urandom_range(0, 40);
            nOut = $urandom_range(0, 10);
            applyStimulus(nIn, nOut, nIn + $urandom_range(0, 2), nOut + $urandom_range(0, 1));
            waitIdle(1000, "random_frame_end");
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
